// File: rtl/bus_mmio_pkg.sv
// Shared types and constants for the bus_mmio MMIO slave and its timeout helper.
package bus_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    PREQ,
    RRESP
  } state_t;

  localparam int         SLOT_LSB     = 8;
  localparam int         SLOT_MSB     = 11;
  localparam logic [7:0] MMIO_TIMEOUT = 8'd255;

  function automatic logic slot_mapped(input logic [3:0] slot, input int nslots);
    return int'(slot) < nslots;
  endfunction

endpackage

// File: rtl/bus_mmio_timeout.sv
// PREQ watchdog for bus_mmio: counts while run is high, clears otherwise,
// and flags expiry once the count sits at MMIO_TIMEOUT.
module bus_mmio_timeout
  import bus_mmio_pkg::*;
(
  input  logic clk_core,
  input  logic reset_n,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q != MMIO_TIMEOUT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == MMIO_TIMEOUT);

endmodule

// File: rtl/bus_mmio.sv
// MMIO bus slave: forwards single-beat bus commands to NSLOTS req/ack peripheral slots.
// Optional macro BUS_MMIO_TIMEOUT_EN aborts a PREQ that sees no ack within MMIO_TIMEOUT cycles.
module bus_mmio
  import bus_mmio_pkg::*;
#(
  parameter int NSLOTS = 8
) (
  input  logic                   clk_core,
  input  logic                   reset_n,
  input  logic                   bmain_cvalid_bmmio,
  output logic                   bmmio_cready,
  input  logic                   bmain_cmd,
  input  logic [11:2]            bmain_addr,
  input  logic                   bmain_wvalid_bmmio,
  output logic                   bmmio_wready,
  input  logic [31:0]            bmain_wdata,
  input  logic [3:0]             bmain_wmask,
  output logic                   bmmio_rvalid,
  input  logic                   bmain_rready_bmmio,
  output logic [31:0]            bmmio_rdata,
  output logic                   bmmio_error,
  input  logic                   bmain_eack_bmmio,
  output logic [NSLOTS-1:0]      mmio_req,
  output logic                   mmio_we,
  output logic [7:2]             mmio_addr,
  output logic [31:0]            mmio_wdata,
  output logic [3:0]             mmio_wmask,
  input  logic [NSLOTS-1:0]      mmio_ack,
  input  logic [32*NSLOTS-1:0]   mmio_rdata
);

  state_t             state_q, state_d;
  logic               cmd_q, cmd_d;
  logic [11:2]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               error_q, error_d;
  logic               error_set;
  logic [3:0]         slot_cur;
  logic [NSLOTS-1:0]  slot_sel;
  logic [31:0]        slot_rdata;
  logic               ack_hit;
  logic               timeout_hit;

  assign slot_cur = addr_q[SLOT_MSB:SLOT_LSB];

  always_comb begin
    slot_sel   = '0;
    slot_rdata = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (slot_cur == 4'(i)) begin
        slot_sel[i] = 1'b1;
        slot_rdata  = mmio_rdata[32*i +: 32];
      end
    end
  end

  // Only the requested slot's ack counts; strays on other slots fall out of the mask.
  assign ack_hit = (state_q == PREQ) && |(slot_sel & mmio_ack);

`ifdef BUS_MMIO_TIMEOUT_EN
  bus_mmio_timeout u_timeout (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .run      (state_q == PREQ),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    error_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bmain_cvalid_bmmio) begin
          cmd_d  = bmain_cmd;
          addr_d = bmain_addr;
          if (!bmain_cmd) begin
            state_d = WDATA;
          end else if (slot_mapped(bmain_addr[SLOT_MSB:SLOT_LSB], NSLOTS)) begin
            state_d = PREQ;
          end else begin
            state_d   = RRESP;
            rdata_d   = '0;
            error_set = 1'b1;
          end
        end
      end
      WDATA: begin
        if (bmain_wvalid_bmmio) begin
          wdata_d = bmain_wdata;
          wmask_d = bmain_wmask;
          if (slot_mapped(slot_cur, NSLOTS)) begin
            state_d = PREQ;
          end else begin
            state_d   = IDLE;
            error_set = 1'b1;
          end
        end
      end
      PREQ: begin
        if (ack_hit) begin
          if (cmd_q) begin
            rdata_d = slot_rdata;
            state_d = RRESP;
          end else begin
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          error_set = 1'b1;
          if (cmd_q) begin
            rdata_d = '0;
            state_d = RRESP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RRESP: begin
        if (bmain_rready_bmmio) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new fault in the same cycle as an acknowledge must not be lost.
    error_d = error_set | (error_q & ~bmain_eack_bmmio);
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign bmmio_cready = (state_q == IDLE);
  assign bmmio_wready = (state_q == WDATA);
  assign bmmio_rvalid = (state_q == RRESP);
  assign bmmio_rdata  = rdata_q;
  assign bmmio_error  = error_q;
  assign mmio_req     = (state_q == PREQ) ? slot_sel : '0;
  assign mmio_we      = ~cmd_q;
  assign mmio_addr    = addr_q[7:2];
  assign mmio_wdata   = wdata_q;
  assign mmio_wmask   = wmask_q;

endmodule
